serial_link_credit_return: RTL

Receiver-side credit manager for the serial link's credit-based flow control. It is the counterpart of the sender's credit counter.
- Tracks occupancy of the local receive buffer, which is sized to NumCredits entries.
- Accumulates one credit for every slot the consumer frees.
- Returns accumulated credits to the peer, either piggybacked on an outgoing data packet or through a dedicated credit-only packet request.
- Sits between the link-layer receive buffer and the link-layer transmit packetizer.

---
 rtl/serial_link_credit_return_if.sv | 29 ++
 rtl/serial_link_credit_return.sv | 88 ++++++++
 2 files changed

// File: rtl/serial_link_credit_return_if.sv
// Credit-return signal bundle between the receive buffer / packetizer side and
// the receiver credit manager.
interface serial_link_credit_return_if #(
  parameter int NumCredits = 8,
  parameter int CreditW    = $clog2(NumCredits) + 1
);
  logic               rx_pkt_valid_i;
  logic               buf_pop_i;
  logic               tx_fire_i;
  logic [CreditW-1:0] tx_credits_o;
  logic               credit_req_o;
  logic [CreditW-1:0] credit_req_cnt_o;
  logic               credit_ack_i;
  logic [CreditW-1:0] occupancy_o;
  logic               overflow_o;
  logic               underflow_o;

  modport slave (
    input  rx_pkt_valid_i, buf_pop_i, tx_fire_i, credit_ack_i,
    output tx_credits_o, credit_req_o, credit_req_cnt_o,
           occupancy_o, overflow_o, underflow_o
  );

  modport master (
    output rx_pkt_valid_i, buf_pop_i, tx_fire_i, credit_ack_i,
    input  tx_credits_o, credit_req_o, credit_req_cnt_o,
           occupancy_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/serial_link_credit_return.sv
// Receiver-side credit manager: tracks buffer occupancy, accumulates freed
// slots as credits and returns them by piggyback or a credit-only request.
module serial_link_credit_return #(
  parameter int NumCredits      = 8,
  parameter int ForceSendThresh = 4,
  parameter int TimeoutCycles   = 64,
  parameter int CreditW         = $clog2(NumCredits) + 1
) (
  input logic clk_i,
  input logic rst_i,
  serial_link_credit_return_if.slave link
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StReq  = 1'b1;
  localparam int TimerW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  localparam logic [CreditW-1:0] Full     = CreditW'(NumCredits);
  localparam logic [CreditW-1:0] Thresh   = CreditW'(ForceSendThresh);
  localparam logic [TimerW-1:0]  TimerMax = TimerW'(TimeoutCycles - 1);

  logic [0:0]         state_q, state_d;
  logic [CreditW-1:0] occ_q, occ_d;
  logic [CreditW-1:0] pending_q, pending_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic rx_only, pop_only, valid_pop, ret_evt;

  always_comb begin
    rx_only   = link.rx_pkt_valid_i & ~link.buf_pop_i;
    pop_only  = link.buf_pop_i & ~link.rx_pkt_valid_i;
    // A pop paired with an rx frees a real slot even at occupancy 0.
    valid_pop = link.buf_pop_i & (link.rx_pkt_valid_i | (occ_q != '0));
    ret_evt   = ((state_q == StIdle) & link.tx_fire_i) |
                ((state_q == StReq) & link.credit_ack_i);

    occ_d = occ_q;
    if (rx_only && occ_q != Full) occ_d = occ_q + 1'b1;
    else if (pop_only && occ_q != '0) occ_d = occ_q - 1'b1;

    ovf_d = ovf_q | (rx_only & (occ_q == Full));
    unf_d = unf_q | (pop_only & (occ_q == '0));

    pending_d = ret_evt ? CreditW'(valid_pop) : pending_q + CreditW'(valid_pop);

    state_d = state_q;
    if (state_q == StIdle) begin
      if (!link.tx_fire_i &&
          ((pending_q >= Thresh) || ((pending_q != '0) && (timer_q == TimerMax))))
        state_d = StReq;
    end else if (link.credit_ack_i) begin
      state_d = StIdle;
    end

    timer_d = '0;
    if (state_q == StIdle && pending_q != '0 && !ret_evt)
      timer_d = (timer_q == TimerMax) ? timer_q : timer_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      occ_q     <= '0;
      pending_q <= '0;
      timer_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Piggyback is suppressed in Req so the outstanding request count stays valid.
  assign link.tx_credits_o     = (state_q == StIdle) ? pending_q : '0;
  assign link.credit_req_o     = (state_q == StReq);
  assign link.credit_req_cnt_o = (state_q == StReq) ? pending_q : '0;
  assign link.occupancy_o      = occ_q;
  assign link.overflow_o       = ovf_q;
  assign link.underflow_o      = unf_q;

endmodule
